// File: rtl/scan_pkg.sv
// Shared SCAN decoder definitions: step type codes, default code size and layer width.
// The scheduler, write-address generator and alpha/beta datapath all import this package.
package scan_pkg;

  localparam int N_LOG_DEFAULT = 10;
  localparam int LAYER_W       = 11;

  typedef enum logic [3:0] {
    TYPE1  = 4'b0000,
    TYPE2  = 4'b0001,
    BOTTOM = 4'b0010,
    TYPE3  = 4'b0011
  } u_type_e;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} sched_state_e;

  typedef enum logic {ENTER, ASCEND} walk_mode_e;

  // Node size N>>depth as a zero-extended layer word.
  function automatic logic [LAYER_W-1:0] layer_of(input int n_log, input int depth);
    return LAYER_W'(1) << (n_log - depth);
  endfunction

endpackage

// File: rtl/scan_scheduler_if.sv
// Step handshake between the SCAN traversal scheduler (master) and the
// address generator / alpha-beta datapath (slave).
interface scan_scheduler_if #(
  parameter int N_LOG  = scan_pkg::N_LOG_DEFAULT,
  parameter int ITER_W = 3
);
  import scan_pkg::*;

  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              step_valid;
  logic              step_ready;
  logic [3:0]        u_type;
  logic [LAYER_W-1:0] layer;
  logic [N_LOG-2:0]  leaf_idx;
  logic [ITER_W-1:0] iter;
  logic              last_step;
  logic              busy;
  logic              done;

  modport master (
    input  start, max_iter, step_ready,
    output step_valid, u_type, layer, leaf_idx, iter, last_step, busy, done
  );

  modport slave (
    output start, max_iter, step_ready,
    input  step_valid, u_type, layer, leaf_idx, iter, last_step, busy, done
  );

endinterface

// File: rtl/scan_phase_stack.sv
// Per-level phase bits of the decoding-tree walk: 0 = left child pending,
// 1 = right child pending. One write (set-left / set-right) and one read port.
module scan_phase_stack #(
  parameter int N_LOG = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_left,
  input  logic             set_right,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_ph
);

  localparam int DEPTH = N_LOG - 1;

  logic [DEPTH-1:0] ph;

  // NOTE: this is a few flops rather than a RAM, so it is reset like any
  // other state; a mid-run rst must not leave stale right-pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          if (set_left)       ph[i] <= 1'b0;
          else if (set_right) ph[i] <= 1'b1;
        end
      end
    end
  end

  // The leaf level has no phase bit; reading it returns 0.
  always_comb begin
    rd_ph = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) rd_ph = ph[i];
    end
  end

endmodule

// File: rtl/scan_scheduler.sv
// SCAN polar decoder tree-traversal controller: walks the length-N tree once per
// iteration and offers one (type, layer) step per valid/ready handshake.
module scan_scheduler
  import scan_pkg::*;
#(
  parameter int N_LOG  = N_LOG_DEFAULT,
  parameter int ITER_W = 3
) (
  input logic               clk,
  input logic               rst,
  scan_scheduler_if.master  bus
);

  localparam int               IDX_W = $clog2(N_LOG);
  localparam logic [IDX_W-1:0] D_BOT = IDX_W'(N_LOG - 1);

  sched_state_e       state;
  logic [IDX_W-1:0]   d;
  logic [ITER_W-1:0]  eff_max;
  u_type_e            type_q;
  logic [LAYER_W-1:0] layer_q;
  logic [N_LOG-2:0]   leaf_q;
  logic [ITER_W-1:0]  iter_q;
  logic               last_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic               accept;
  logic [IDX_W-1:0]   d_nxt;
  walk_mode_e         mode_nxt;
  u_type_e            type_nxt;
  logic [LAYER_W-1:0] layer_nxt;
  logic [ITER_W-1:0]  iter_nxt;
  logic               last_nxt;
  logic               leaf_inc;
  logic               iter_end;
  logic               set_left;
  logic               set_right;
  logic               ph_nxt;

  assign accept = (state == ISSUE) && valid_q && bus.step_ready;

  scan_phase_stack #(.N_LOG(N_LOG), .IDX_W(IDX_W)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .set_left  (set_left),
    .set_right (set_right),
    .wr_idx    (d),
    .rd_idx    (d_nxt),
    .rd_ph     (ph_nxt)
  );

  // The offered step's type already encodes the walk mode and child phase, so
  // the step that follows it is derived from type_q and d alone.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    d_nxt     = d;
    mode_nxt  = ENTER;
    leaf_inc  = 1'b0;
    iter_end  = 1'b0;
    set_left  = 1'b0;
    set_right = 1'b0;
    unique case (type_q)
      TYPE1: begin
        d_nxt    = d + 1'b1;
        set_left = accept;
      end
      BOTTOM: begin
        d_nxt    = d - 1'b1;
        mode_nxt = ASCEND;
        leaf_inc = 1'b1;
      end
      TYPE2: begin
        d_nxt     = d + 1'b1;
        set_right = accept;
      end
      TYPE3: begin
        if (d == '0) begin
          iter_end = 1'b1;
          d_nxt    = '0;
        end else begin
          d_nxt    = d - 1'b1;
          mode_nxt = ASCEND;
        end
      end
      default: ;
    endcase

    if (mode_nxt == ENTER) type_nxt = (d_nxt == D_BOT) ? BOTTOM : TYPE1;
    else                   type_nxt = ph_nxt ? TYPE3 : TYPE2;

    // TYPE3 reports the child size, one level below its own node.
    layer_nxt = (type_nxt == TYPE3) ? layer_of(N_LOG, int'(d_nxt) + 1)
                                    : layer_of(N_LOG, int'(d_nxt));
    iter_nxt  = iter_end ? iter_q + 1'b1 : iter_q;
    last_nxt  = (type_nxt == TYPE3) && (d_nxt == '0) &&
                (({1'b0, iter_nxt} + 1'b1) >= {1'b0, eff_max});
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      d       <= '0;
      eff_max <= '0;
      type_q  <= TYPE1;
      layer_q <= '0;
      leaf_q  <= '0;
      iter_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state   <= ISSUE;
            d       <= '0;
            eff_max <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
            type_q  <= TYPE1;
            layer_q <= layer_of(N_LOG, 0);
            leaf_q  <= '0;
            iter_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (last_q) begin
              state   <= DONE;
              d       <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              d       <= d_nxt;
              type_q  <= type_nxt;
              layer_q <= layer_nxt;
              iter_q  <= iter_nxt;
              last_q  <= last_nxt;
              if (iter_end)      leaf_q <= '0;
              else if (leaf_inc) leaf_q <= leaf_q + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.step_valid = valid_q;
  assign bus.u_type     = type_q;
  assign bus.layer      = layer_q;
  assign bus.leaf_idx   = leaf_q;
  assign bus.iter       = iter_q;
  assign bus.last_step  = last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: N_LOG=3 and N_LOG=10 instances checked
// against a leaf-by-leaf model of the SCAN step sequence.
module tb_scan_scheduler;

  localparam logic [3:0] T1 = 4'b0000;
  localparam logic [3:0] T2 = 4'b0001;
  localparam logic [3:0] TB = 4'b0010;
  localparam logic [3:0] T3 = 4'b0011;

  typedef struct {
    logic [3:0]  t;
    logic [10:0] layer;
    int          leaf;
    int          it;
    bit          last;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       step_ready = 1'b0;
  logic       sel10 = 1'b0;
  logic [2:0] max_iter = 3'd0;

  int tests  = 0;
  int failed = 0;

  step_t exp_q[$];

  scan_scheduler_if #(.N_LOG(3),  .ITER_W(3)) if3  ();
  scan_scheduler_if #(.N_LOG(10), .ITER_W(3)) if10 ();

  scan_scheduler #(.N_LOG(3), .ITER_W(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.master)
  );

  scan_scheduler #(.N_LOG(10), .ITER_W(3)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (if10.master)
  );

  always #5 clk = ~clk;

  assign if3.start       = start & ~sel10;
  assign if3.max_iter    = max_iter;
  assign if3.step_ready  = step_ready;
  assign if10.start      = start & sel10;
  assign if10.max_iter   = max_iter;
  assign if10.step_ready = step_ready;

  // Observed outputs of whichever instance is under test.
  logic        m_valid, m_last, m_busy, m_done;
  logic [3:0]  m_type;
  logic [10:0] m_layer;
  logic [9:0]  m_leaf;
  logic [2:0]  m_iter;

  assign m_valid = sel10 ? if10.step_valid : if3.step_valid;
  assign m_last  = sel10 ? if10.last_step  : if3.last_step;
  assign m_busy  = sel10 ? if10.busy       : if3.busy;
  assign m_done  = sel10 ? if10.done       : if3.done;
  assign m_type  = sel10 ? if10.u_type     : if3.u_type;
  assign m_layer = sel10 ? if10.layer      : if3.layer;
  assign m_leaf  = sel10 ? 10'(if10.leaf_idx) : 10'(if3.leaf_idx);
  assign m_iter  = sel10 ? if10.iter       : if3.iter;

  // Model: leaf pairs are visited left to right. Before leaf j>0, climb out of
  // the ctz(j) subtrees just finished (TYPE3s), turn right at the node of size
  // 4<<ctz(j) (TYPE2), then descend to the leaf level (TYPE1s).
  function automatic void push_step(input logic [3:0] t, input int layer,
                                    input int leaf, input int it);
    step_t s;
    s.t = t; s.layer = 11'(layer); s.leaf = leaf; s.it = it; s.last = 1'b0;
    exp_q.push_back(s);
  endfunction

  function automatic void build_ref(input int n_log, input int mi);
    int eff;
    int tz;
    int v;
    eff = (mi == 0) ? 1 : mi;
    exp_q.delete();
    for (int it = 0; it < eff; it++) begin
      for (int j = 0; j < (1 << (n_log - 1)); j++) begin
        if (j == 0) begin
          for (int k = n_log; k >= 2; k--) push_step(T1, 1 << k, 0, it);
        end else begin
          tz = 0; v = j;
          while (v % 2 == 0) begin tz++; v = v / 2; end
          for (int k = 0; k < tz; k++) push_step(T3, 2 << k, 0, it);
          push_step(T2, 4 << tz, 0, it);
          for (int k = tz - 1; k >= 0; k--) push_step(T1, 4 << k, 0, it);
        end
        push_step(TB, 2, j, it);
      end
      for (int k = 0; k < n_log - 1; k++) push_step(T3, 2 << k, 0, it);
    end
    exp_q[exp_q.size() - 1].last = 1'b1;
  endfunction

  task automatic check_reset_vals(input string tag);
    tests++;
    if (m_valid !== 1'b0 || m_type !== T1 || m_layer !== 11'd0 || m_leaf !== 10'd0 ||
        m_iter !== 3'd0 || m_last !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin
      failed++;
      $display("FAIL %s: got valid=%b type=%h layer=%0d leaf=%0d iter=%0d last=%b busy=%b done=%b, expected all zero",
               tag, m_valid, m_type, m_layer, m_leaf, m_iter, m_last, m_busy, m_done);
    end
  endtask

  task automatic do_start(input logic [2:0] mi);
    @(negedge clk);
    max_iter = mi;
    start    = 1'b1;
  endtask

  // Consumes steps from the selected DUT and compares them with exp_q.
  // stop_after>0 returns after that many accepts; otherwise the done pulse is checked.
  task automatic run_stream(input int ready_pct, input bit poke, input int stop_after,
                            input bit start_in_done, input string tag);
    int          idx = 0;
    int          cyc = 0;
    int          limit;
    bit          stalled = 1'b0;
    bit          r;
    step_t       e;
    logic [3:0]  s_type;
    logic [10:0] s_layer;
    logic [9:0]  s_leaf;
    logic [2:0]  s_iter;
    logic        s_last;
    limit = (stop_after > 0) ? stop_after : exp_q.size();
    while (idx < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        tests++; failed++;
        $display("FAIL %s timeout: %0d of %0d steps accepted", tag, idx, limit);
        start = 1'b0;
        return;
      end
      if (stalled) begin
        tests++;
        if (m_valid !== 1'b1 || m_type !== s_type || m_layer !== s_layer ||
            m_leaf !== s_leaf || m_iter !== s_iter || m_last !== s_last) begin
          failed++;
          $display("FAIL %s stall_hold step %0d: got valid=%b type=%h layer=%0d leaf=%0d, expected 1/%h/%0d/%0d",
                   tag, idx, m_valid, m_type, m_layer, m_leaf, s_type, s_layer, s_leaf);
        end
      end
      if (ready_pct >= 100) begin
        tests++;
        if (m_valid !== 1'b1) begin
          failed++;
          $display("FAIL %s bubble at step %0d: step_valid=%b, expected 1", tag, idx, m_valid);
        end
      end
      r          = ($urandom_range(99) < ready_pct);
      step_ready = r;
      if (poke) begin
        max_iter = 3'($urandom);
        start    = ($urandom_range(3) == 0);
      end else begin
        start = 1'b0;
      end
      if (m_valid === 1'b1 && r) begin
        tests++;
        e = exp_q[idx];
        if (m_type !== e.t || m_layer !== e.layer || (e.t == TB && m_leaf !== 10'(e.leaf)) ||
            m_iter !== 3'(e.it) || m_last !== e.last || m_busy !== 1'b1) begin
          failed++;
          $display("FAIL %s step %0d: got type=%h layer=%0d leaf=%0d iter=%0d last=%b busy=%b, expected type=%h layer=%0d leaf=%0d iter=%0d last=%b busy=1",
                   tag, idx, m_type, m_layer, m_leaf, m_iter, m_last, m_busy,
                   e.t, e.layer, e.leaf, e.it, e.last);
        end
        idx++;
        if (idx == limit) start = 1'b0;
      end
      stalled = (m_valid === 1'b1) && !r;
      s_type = m_type; s_layer = m_layer; s_leaf = m_leaf; s_iter = m_iter; s_last = m_last;
    end
    if (stop_after == 0) begin
      @(negedge clk);
      step_ready = 1'b0;
      start      = start_in_done;
      tests++;
      if (m_done !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
        failed++;
        $display("FAIL %s done_pulse: got done=%b busy=%b valid=%b, expected 1/0/0", tag, m_done, m_busy, m_valid);
      end
      @(negedge clk);
      tests++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
        failed++;
        $display("FAIL %s after_done: got done=%b busy=%b valid=%b, expected 0/0/0", tag, m_done, m_busy, m_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; max_iter = 3'd2; step_ready = 1'b1;
    repeat (3) @(negedge clk);
    sel10 = 1'b0; #1;
    check_reset_vals("reset_n3");
    sel10 = 1'b1; #1;
    check_reset_vals("reset_n10");
    rst = 1'b0; start = 1'b0; step_ready = 1'b0;
    @(negedge clk);
    check_reset_vals("idle_n10");
    sel10 = 1'b0; #1;
    check_reset_vals("idle_n3");
  endtask

  task automatic test_single_iter_n3();
    sel10 = 1'b0;
    build_ref(3, 1);
    do_start(3'd1);
    run_stream(100, 1'b0, 0, 1'b0, "n3_1iter");
  endtask

  task automatic test_multi_iter_n10();
    sel10 = 1'b1;
    build_ref(10, 2);
    do_start(3'd2);
    run_stream(100, 1'b0, 0, 1'b0, "n10_2iter");
  endtask

  task automatic test_stall();
    sel10 = 1'b0;
    build_ref(3, 3);
    do_start(3'd3);
    run_stream(50, 1'b1, 0, 1'b0, "n3_stall");
    sel10 = 1'b1;
    build_ref(10, 1);
    do_start(3'd1);
    run_stream(70, 1'b0, 0, 1'b0, "n10_stall");
  endtask

  task automatic test_zero_iter();
    sel10 = 1'b0;
    build_ref(3, 0);
    do_start(3'd0);
    run_stream(100, 1'b1, 0, 1'b0, "zero_iter");
  endtask

  task automatic test_reset_mid_run();
    sel10 = 1'b0;
    build_ref(3, 1);
    do_start(3'd1);
    run_stream(100, 1'b0, 4, 1'b0, "rst_mid");
    @(negedge clk);
    tests++;
    if (m_valid !== 1'b1 || m_type !== exp_q[4].t || m_layer !== exp_q[4].layer) begin
      failed++;
      $display("FAIL rst_mid step5: got valid=%b type=%h layer=%0d, expected 1/%h/%0d",
               m_valid, m_type, m_layer, exp_q[4].t, exp_q[4].layer);
    end
    rst = 1'b1; step_ready = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid_after");
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (m_done !== 1'b0 || m_valid !== 1'b0 || m_busy !== 1'b0) begin
        failed++;
        $display("FAIL rst_mid_quiet: got done=%b valid=%b busy=%b, expected 0/0/0", m_done, m_valid, m_busy);
      end
    end
    do_start(3'd1);
    run_stream(100, 1'b0, 0, 1'b0, "rst_replay");
  endtask

  task automatic test_start_in_done();
    sel10 = 1'b0;
    build_ref(3, 2);
    do_start(3'd2);
    run_stream(100, 1'b0, 0, 1'b1, "start_in_done");
    // start has been high since the DONE cycle; the IDLE edge just ahead accepts it
    run_stream(100, 1'b0, 0, 1'b0, "start_after_done");
  endtask

  initial begin
    test_reset();
    test_single_iter_n3();
    test_multi_iter_n10();
    test_stall();
    test_zero_iter();
    test_reset_mid_run();
    test_start_in_done();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
